regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised successor to the RV32I integer register file, with two write ports and two combinational read ports.
- Adds configurable depth and width, a hardwired-zero option, optional write-to-read bypass, and a sequenced clear engine with a busy flag.
- Sits between the decode stage (read addresses) and the writeback stage. Port 3 carries ALU/load writeback; port 4 carries a second retire path, such as a multiplier or CSR.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 5, width of all address ports.
- NUM_REGS, 32, number of registers. Must be ≤ 2^ADDR_WIDTH. Addresses ≥ NUM_REGS read 0, and writes to them are dropped.
- ZERO_REG, 1. When 1, register 0 always reads 0 and writes to it are dropped.
- BYPASS, 1. When 1, a read whose address matches a same-cycle write returns the write data.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- A1  in  ADDR_WIDTH  read address, port 1.
- A2  in  ADDR_WIDTH  read address, port 2.
- RD1  out  DATA_WIDTH  read data, port 1 (combinational).
- RD2  out  DATA_WIDTH  read data, port 2 (combinational).
- A3  in  ADDR_WIDTH  write address, port 3 (high priority).
- WD3  in  DATA_WIDTH  write data, port 3.
- WE3  in  1  write enable, port 3.
- A4  in  ADDR_WIDTH  write address, port 4 (low priority).
- WD4  in  DATA_WIDTH  write data, port 4.
- WE4  in  1  write enable, port 4.
- clear  in  1  single-cycle request to zero all registers.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Two-state FSM, IDLE and CLEAR, with a clear counter cnt of width ADDR_WIDTH.
- rst sampled high: next state is CLEAR and cnt is 0. This applies from any state, so a reset during a clear restarts the sequence. While rst is held high, the block stays in CLEAR with cnt 0.
- CLEAR, each cycle rst is low:
  - reg[cnt] is written 0 and cnt increments.
  - When cnt = NUM_REGS-1 is cleared, next state is IDLE.
  - The sequence takes exactly NUM_REGS cycles after rst is deasserted.
- IDLE: clear sampled high moves to CLEAR with cnt 0. The same NUM_REGS-cycle sequence then runs.
- clear asserted during CLEAR is ignored.
- busy is a registered output, high exactly while state = CLEAR. Its value is 1 in the first cycle after rst is sampled high.
- While busy is high:
  - WE3 and WE4 are ignored, and no user write occurs.
  - RD1 and RD2 return 0.
- Writes in IDLE, committed on the rising edge:
  - WE3 writes WD3 to reg[A3]; WE4 writes WD4 to reg[A4].
  - If both are enabled and A3 = A4, only port 3 commits.
  - A write is dropped if its address is ≥ NUM_REGS, or if its address is 0 and ZERO_REG = 1.
- Reads are combinational and have no latency.
- RD1 = 0 in any of these cases: busy is high; A1 ≥ NUM_REGS; A1 = 0 and ZERO_REG = 1.
- With BYPASS = 1, for a read not covered by those zero cases:
  - If WE3 is high and A3 = A1, RD1 = WD3.
  - Otherwise, if WE4 is high and A4 = A1, RD1 = WD4.
  - Otherwise, RD1 = reg[A1].
  - A dropped write is never bypassed.
- With BYPASS = 0, RD1 = reg[A1], the pre-edge value.
- RD2 follows the same rules as RD1, using A2.
- Register contents are undefined only before the first reset. Once the clear sequence completes, every register holds 0.
- No other state exists.

Test Plan:
- Reset and clear timing: pulse rst for 1 cycle. Required: busy = 1 for exactly 32 cycles, then 0; every register then reads 0.
- Zero register: write WE3 = 1, A3 = 0, WD3 = 0xDEADBEEF, then read A1 = 0. Required: RD1 = 0. With ZERO_REG = 0, required: RD1 = 0xDEADBEEF on the next cycle.
- Write-port collision: A3 = A4 = 5, WD3 = 0x11, WD4 = 0x22, both enables high. Required: reg5 reads 0x11 after the edge. With A4 = 6 instead, required: reg5 = 0x11 and reg6 = 0x22.
- Bypass: reg7 = 0x100. In the same cycle set A1 = 7, WE4 = 1, A4 = 7, WD4 = 0x200. Required: RD1 = 0x200 with BYPASS = 1, and 0x100 with BYPASS = 0. Both cases read 0x200 on the next cycle.
- Clear during operation:
  - With regs 1..31 loaded, pulse clear. Required: busy rises on the next cycle and reads return 0 while busy.
  - A WE3 issued during busy is dropped.
  - Assert rst at cycle 10 of the clear. Required: the sequence restarts, and busy stays high for 32 cycles after rst deasserts.
- Depth parametrisation: with NUM_REGS = 16 and ADDR_WIDTH = 5, write A3 = 20. Required: the write is dropped and RD1 for A1 = 20 returns 0. The clear sequence lasts 16 cycles.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: two read ports, two write ports, clear request and busy flag.
interface regfile_mp_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] A1;
    logic [ADDR_WIDTH-1:0] A2;
    logic [DATA_WIDTH-1:0] RD1;
    logic [DATA_WIDTH-1:0] RD2;
    logic [ADDR_WIDTH-1:0] A3;
    logic [DATA_WIDTH-1:0] WD3;
    logic                  WE3;
    logic [ADDR_WIDTH-1:0] A4;
    logic [DATA_WIDTH-1:0] WD4;
    logic                  WE4;
    logic                  clear;
    logic                  busy;

    modport master (
        output A1, A2, A3, WD3, WE3, A4, WD4, WE4, clear,
        input  RD1, RD2, busy
    );

    modport slave (
        input  A1, A2, A3, WD3, WE3, A4, WD4, WE4, clear,
        output RD1, RD2, busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Two-write / two-read register file with optional zero register, write bypass
// and a one-register-per-cycle clear engine that runs after reset or on request.
module regfile_mp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS   = 32,
    parameter bit          ZERO_REG   = 1'b1,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned AW1   = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0]   LIMIT = AW1'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  we3_ok;
    logic                  we4_ok;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;

    // An address is usable when it is implemented and not the hardwired zero register.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < LIMIT) && !(ZERO_REG && (a == '0));
    endfunction

    assign we3_ok = bus.WE3 && addr_ok(bus.A3) && (state == IDLE);
    assign we4_ok = bus.WE4 && addr_ok(bus.A4) && (state == IDLE);

    // Clear engine, user writes and busy flag; port 3 is written last so it wins a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (we4_ok) mem[bus.A4] <= bus.WD4;
                    if (we3_ok) mem[bus.A3] <= bus.WD3;
                    if (bus.clear) begin
                        state  <= CLEAR;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[cnt] <= '0;
                    cnt      <= cnt + ADDR_WIDTH'(1);
                    if (cnt == LAST) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Read port 1: bypass from an accepted same-cycle write, then zero the forced-zero cases.
    always_comb begin
        rd1 = mem[bus.A1];
        if (BYPASS) begin
            if (we3_ok && (bus.A3 == bus.A1))      rd1 = bus.WD3;
            else if (we4_ok && (bus.A4 == bus.A1)) rd1 = bus.WD4;
        end
        if (busy_q || !addr_ok(bus.A1)) rd1 = '0;
    end

    always_comb begin
        rd2 = mem[bus.A2];
        if (BYPASS) begin
            if (we3_ok && (bus.A3 == bus.A2))      rd2 = bus.WD3;
            else if (we4_ok && (bus.A4 == bus.A2)) rd2 = bus.WD4;
        end
        if (busy_q || !addr_ok(bus.A2)) rd2 = '0;
    end

    assign bus.RD1  = rd1;
    assign bus.RD2  = rd2;
    assign bus.busy = busy_q;
endmodule
